// File: rtl/decimal_arb_pkg.sv
// Shared types and constants for the ten-way decimal request arbiter.
// Index helpers keep the 0-9 wrap arithmetic in one place.
package decimal_arb_pkg;

  localparam int N            = 10;
  localparam int IDX_W        = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Next index after i, wrapping 9 -> 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/decimal_request_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// wrapping through 9 -> 0. Returns a one-hot pick and its binary index.
module rr_pick
  import decimal_arb_pkg::*;
(
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] pick_idx_o,
  output logic             found_o
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  always_comb begin
    pick_o     = '0;
    pick_idx_o = '0;
    found_o    = 1'b0;
    cand       = '0;
    for (int off = 0; off < N; off++) begin
      // ptr + off can reach 18; subtract N once to fold it back into 0..9.
      cand = {1'b0, ptr_i} + CW'(off);
      if (cand >= CW'(N)) begin
        cand = cand - CW'(N);
      end
      if (!found_o && req_i[cand[IDX_W-1:0]]) begin
        found_o    = 1'b1;
        pick_idx_o = cand[IDX_W-1:0];
        pick_o     = N'(1) << cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/decimal_request_arbiter.sv
// Round-robin arbiter for ten requesters with owner release and hold timeout.
// Grants are registered; every release is followed by at least one IDLE cycle.
module decimal_request_arbiter
  import decimal_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output arb_state_t       dbg_state_o,
  output logic [IDX_W-1:0] dbg_ptr_o
);

  // Handshake: a requester holds req[i] high until it sees gnt[i]; the owner
  // keeps req[i] high for the whole tenure and ends it either by pulsing done
  // or by dropping req[i]. done and req changes from non-owners are ignored
  // while BUSY, and done is ignored entirely in IDLE.

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
      $error("MAX_HOLD must lie in 2..15");
    end
  endgenerate

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic [N-1:0]     pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             release_now;

  rr_pick u_rr_pick (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx),
    .found_o    (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    release_now = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d       = pick;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Priority: done, then owner withdrawal, then forced timeout.
        // gnt is one-hot, so masking req with it isolates the owner's line.
        if (done) begin
          release_now = 1'b1;
        end else if ((req & gnt_q) == '0) begin
          release_now = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          release_now = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end

        if (release_now) begin
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          ptr_d       = wrap_inc(gnt_idx_q);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = gnt_idx_q;
  assign gnt_valid   = gnt_valid_q;
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_decimal_request_arbiter.sv
// Directed bench for decimal_request_arbiter: grant order, release paths,
// timeout, pointer wrap and asynchronous reset mid-grant.
module tb_decimal_request_arbiter;
  import decimal_arb_pkg::*;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;
  arb_state_t       dbg_state;
  logic [IDX_W-1:0] dbg_ptr;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [15:0] obs;
  logic [15:0] exp_v;
  logic [3:0]  exp_q[$];

  assign obs = {gnt, gnt_idx, gnt_valid, timeout};

  decimal_request_arbiter #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .timeout     (timeout),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  // Expected {gnt, gnt_idx, gnt_valid, timeout} for a given grant state.
  function automatic logic [15:0] pack(input bit v, input int idx, input bit to);
    logic [9:0] oh;
    oh = v ? (10'b1 << idx) : 10'b0;
    return {oh, v ? 4'(idx) : 4'd0, v, to};
  endfunction

  // Advance one rising edge and park on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();
    vec_cnt++;
    if (obs !== pack(0, 0, 0)) begin
      err_cnt++; $display("FAIL reset_outputs got %h exp %h", obs, pack(0, 0, 0));
    end
    vec_cnt++;
    if (dbg_ptr !== 4'd0 || dbg_state !== IDLE) begin
      err_cnt++; $display("FAIL reset_state got ptr=%0d st=%0d exp ptr=0 st=0", dbg_ptr, dbg_state);
    end
  endtask

  task automatic test_first_grant();
    done = 1'b1;  // done in IDLE must be ignored
    step();
    done = 1'b0;
    vec_cnt++;
    if (obs !== pack(0, 0, 0) || dbg_state !== IDLE) begin
      err_cnt++; $display("FAIL idle_done got %h exp %h", obs, pack(0, 0, 0));
    end
    req = 10'b0000000001;
    step();
    vec_cnt++;
    if (obs !== pack(1, 0, 0)) begin
      err_cnt++; $display("FAIL first_grant got %h exp %h", obs, pack(1, 0, 0));
    end
    done = 1'b1; req = '0;
    step();
    done = 1'b0;
    vec_cnt++;
    if (obs !== pack(0, 0, 0) || dbg_ptr !== 4'd1) begin
      err_cnt++; $display("FAIL first_release got %h ptr=%0d exp %h ptr=1", obs, dbg_ptr, pack(0, 0, 0));
    end
  endtask

  task automatic test_alternate();
    exp_q = {4'd2, 4'd9, 4'd2, 4'd9};
    req = 10'b1000000100;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = pack(1, int'(exp_q[0]), 0);
      void'(exp_q.pop_front());
      vec_cnt++;
      if (obs !== exp_v) begin
        err_cnt++; $display("FAIL alt_grant%0d got %h exp %h", i, obs, exp_v);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      vec_cnt++;
      if (obs !== pack(0, 0, 0)) begin
        err_cnt++; $display("FAIL alt_dead%0d got %h exp %h", i, obs, pack(0, 0, 0));
      end
    end
  endtask

  task automatic test_wrap();
    vec_cnt++;
    if (dbg_ptr !== 4'd0) begin
      err_cnt++; $display("FAIL wrap_ptr got %0d exp 0", dbg_ptr);
    end
    req = 10'b0000000011;
    step();
    vec_cnt++;
    if (obs !== pack(1, 0, 0)) begin
      err_cnt++; $display("FAIL wrap_grant got %h exp %h", obs, pack(1, 0, 0));
    end
    done = 1'b1; req = '0;
    step();
    done = 1'b0;
  endtask

  task automatic test_timeout();
    int hi_cnt;
    req = 10'b0000010000;  // ptr=1, only requester 4
    step();
    vec_cnt++;
    if (obs !== pack(1, 4, 0)) begin
      err_cnt++; $display("FAIL to_grant got %h exp %h", obs, pack(1, 4, 0));
    end
    hi_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!gnt_valid) break;
      hi_cnt++;
    end
    vec_cnt++;
    if (hi_cnt !== 8) begin
      err_cnt++; $display("FAIL to_length got %0d exp 8", hi_cnt);
    end
    vec_cnt++;
    if (obs !== pack(0, 0, 1) || dbg_ptr !== 4'd5) begin
      err_cnt++; $display("FAIL to_pulse got %h ptr=%0d exp %h ptr=5", obs, dbg_ptr, pack(0, 0, 1));
    end
    req = 10'b0000110000;
    step();
    vec_cnt++;
    if (obs !== pack(1, 5, 0)) begin
      err_cnt++; $display("FAIL to_resume got %h exp %h", obs, pack(1, 5, 0));
    end
  endtask

  task automatic test_withdraw();
    step();
    req = 10'b0000010000;  // owner 5 drops its line, 4 stays: no preemption
    step();
    vec_cnt++;
    if (obs !== pack(0, 0, 0) || dbg_ptr !== 4'd6) begin
      err_cnt++; $display("FAIL withdraw got %h ptr=%0d exp %h ptr=6", obs, dbg_ptr, pack(0, 0, 0));
    end
    req = '0;
    step();
  endtask

  task automatic test_done_vs_timeout();
    int hi_cnt;
    req = 10'b0001000000;
    step();
    vec_cnt++;
    if (obs !== pack(1, 6, 0)) begin
      err_cnt++; $display("FAIL dvt_grant got %h exp %h", obs, pack(1, 6, 0));
    end
    hi_cnt = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (gnt_valid) hi_cnt++;
    end
    vec_cnt++;
    if (hi_cnt !== 8) begin
      err_cnt++; $display("FAIL dvt_hold got %0d exp 8", hi_cnt);
    end
    done = 1'b1;  // coincides with the forced-release edge
    step();
    done = 1'b0;
    vec_cnt++;
    if (obs !== pack(0, 0, 0) || dbg_ptr !== 4'd7) begin
      err_cnt++; $display("FAIL dvt_release got %h ptr=%0d exp %h ptr=7", obs, dbg_ptr, pack(0, 0, 0));
    end
  endtask

  task automatic test_reset_mid_grant();
    step();
    vec_cnt++;
    if (obs !== pack(1, 6, 0)) begin
      err_cnt++; $display("FAIL rmg_grant got %h exp %h", obs, pack(1, 6, 0));
    end
    step();
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (obs !== pack(0, 0, 0) || dbg_ptr !== 4'd0 || dbg_state !== IDLE) begin
      err_cnt++; $display("FAIL rmg_async got %h ptr=%0d exp %h ptr=0", obs, dbg_ptr, pack(0, 0, 0));
    end
    @(negedge clk);
    rst = 1'b0;
    req = 10'b1111111111;
    step();
    vec_cnt++;
    if (obs !== pack(1, 0, 0)) begin
      err_cnt++; $display("FAIL rmg_resume got %h exp %h", obs, pack(1, 0, 0));
    end
    done = 1'b1;
    step();
    done = 1'b0;
    vec_cnt++;
    if (obs !== pack(0, 0, 0) || dbg_ptr !== 4'd1) begin
      err_cnt++; $display("FAIL rmg_release got %h ptr=%0d exp %h ptr=1", obs, dbg_ptr, pack(0, 0, 0));
    end
    step();
    vec_cnt++;
    if (obs !== pack(1, 1, 0)) begin
      err_cnt++; $display("FAIL rmg_next got %h exp %h", obs, pack(1, 1, 0));
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;
    test_reset();
    test_first_grant();
    test_alternate();
    test_wrap();
    test_timeout();
    test_withdraw();
    req = 10'b0001000000;
    test_done_vs_timeout();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/decimal_request_arbiter.md
# decimal_request_arbiter

Round-robin arbiter sharing one resource among ten requesters, indexed 0-9 like the decimal one-hot encoder lines. Each grant is issued both as a one-hot vector and as a 4-bit binary index. A grant is held until the owner releases it or a hold timeout expires. The block sits in front of the shared decimal-indexed datapath and sequences which source drives it.

## Interface
- N, 10, number of requesters; fixed at 10, index width 4.
- MAX_HOLD, 8, maximum cycles a grant may be held (range 2-15).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  10  request lines; bit i = requester i, level-sensitive.
- done  input  1  release pulse from the current owner, sampled only in BUSY.
- gnt  output  10  one-hot grant, registered; all zero when no grant.
- gnt_idx  output  4  binary index of granted requester, 0-9, registered.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is force-released.

## Operation
- Reset values: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
- Two states: IDLE and BUSY.
- IDLE with req==0: stay in IDLE; outputs remain zero.
- IDLE with req!=0: select the first set bit searching ptr, ptr+1, … 9, 0, … ptr-1.
  - Register gnt, gnt_idx and gnt_valid=1.
  - Clear hold_cnt and go to BUSY.
- BUSY: hold_cnt increments each cycle. Release conditions, in priority order:
  1. done=1: normal release, timeout stays 0.
  2. req[gnt_idx]=0: owner withdrew; normal release.
  3. hold_cnt==MAX_HOLD-1: forced release; timeout=1 for that cycle.
- On any release:
  - gnt, gnt_valid and gnt_idx clear to 0 on the same edge.
  - ptr = gnt_idx+1, wrapping 9→0.
  - state returns to IDLE.
- done in the same cycle as the timeout condition: done wins, no timeout pulse.
- done or req changes on non-owner lines while BUSY: ignored; no preemption.
- done in IDLE: ignored.
- Invariant: gnt_idx always equals the binary encoding of gnt; gnt is never multi-hot.

## Timing
- Grant latency: req sampled on edge k in IDLE → gnt/gnt_valid high after edge k; one cycle from request to visible grant.
- Minimum grant length: 1 cycle, when done is high on the first BUSY cycle.
- Maximum grant length: MAX_HOLD cycles.
- Every release is followed by at least one IDLE cycle. Back-to-back grants are therefore spaced by one dead cycle (gnt_valid low for exactly 1 cycle).
- timeout is asserted in the cycle after the last BUSY edge and lasts exactly 1 cycle.
- Reset mid-grant: all outputs clear asynchronously on rst rise. Arbitration resumes from ptr=0 on the first edge after rst falls.
- hold_cnt width is 4 bits; it never wraps because release occurs at MAX_HOLD-1.

## Structure
- Shared package decimal_arb_pkg holds:
  - constants N=10 and IDX_W=4;
  - typedef arb_state_t {IDLE, BUSY};
  - default MAX_HOLD.
- One sub-module, rr_pick, is purely combinational. It takes req and ptr and returns a one-hot pick and its 4-bit index by rotating the search start, last index wins none (first-found only).
- Top-level holds the FSM, ptr, hold_cnt and output registers.

## Test plan
- Reset then req=10'b0000000001 → after 1 edge gnt=0000000001, gnt_idx=0, gnt_valid=1. done pulse → gnt=0, ptr=1.
- req=10'b1000000100 held, done pulsed each grant → grants alternate idx 2, 9, 2, 9, each separated by 1 idle cycle.
- Grant to idx 9 released → ptr wraps to 0. Then req=10'b0000000011 → grant idx 0.
- req=10'b0000010000 held, no done, MAX_HOLD=8 → gnt_valid high exactly 8 cycles, timeout pulses once, next grant resumes from ptr=5.
- done coincident with the timeout cycle → release with timeout=0. Owner drops req mid-grant → release next edge, no timeout.
- rst asserted while gnt_idx=6 → outputs zero immediately. After release, req=10'b1111111111 → grant idx 0.
